// File: rtl/aes_word_serializer.sv
// aes_word_serializer: unpacks one 128-bit AES state into four WORD_W-bit words,
// most-significant word first, over a valid/ready handshake. Each word carries
// its 2-bit index so it can drive the word-assembly register select directly.
//
// Optional build macro AES_SER_LAST_EN adds out_last and word_cnt outputs.
module aes_word_serializer #(
  parameter int unsigned WORD_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [4*WORD_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
`ifdef AES_SER_LAST_EN
  output logic                out_last,
  output logic [1:0]          word_cnt,
`endif
  output logic [7:0]          block_cnt
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              r_state;
  logic [1:0]          r_idx;
  logic [4*WORD_W-1:0] r_hold;
  logic [7:0]          r_block_cnt;

  logic                w_send;
  logic                w_last_word;

  assign w_send      = (r_state == StSend);
  assign w_last_word = (r_idx == 2'd3);

  // Only combinational input-to-output path: out_ready -> in_ready on the last word,
  // which lets the next block be captured on the same edge the last word leaves.
  assign in_ready  = !w_send || (w_last_word && out_ready);
  assign out_valid = w_send;
  assign busy      = w_send;
  assign out_sel   = r_idx;
  assign block_cnt = r_block_cnt;

`ifdef AES_SER_LAST_EN
  assign out_last = w_send && w_last_word;
  assign word_cnt = r_idx;
`endif

  // Select the held word for the current index, most-significant word first.
  always_comb begin
    out_data = '0;
    unique case (r_idx)
      2'd0: out_data = r_hold[4*WORD_W-1:3*WORD_W];
      2'd1: out_data = r_hold[3*WORD_W-1:2*WORD_W];
      2'd2: out_data = r_hold[2*WORD_W-1:WORD_W];
      2'd3: out_data = r_hold[WORD_W-1:0];
      default: out_data = '0;
    endcase
  end

  // Control FSM, word index, hold register and completed-block counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= StIdle;
      r_idx       <= 2'd0;
      r_hold      <= '0;
      r_block_cnt <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_hold  <= in_data;
            r_idx   <= 2'd0;
            r_state <= StSend;
          end
        end
        StSend: begin
          // Stalls (out_ready low) leave every register untouched.
          if (out_ready) begin
            if (!w_last_word) begin
              r_idx <= r_idx + 2'd1;
            end else begin
              r_block_cnt <= r_block_cnt + 8'd1;
              r_idx       <= 2'd0;
              if (in_valid) begin
                r_hold <= in_data;
              end else begin
                r_state <= StIdle;
              end
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_serializer.sv
// Self-checking bench for aes_word_serializer. Expected words are pushed to a
// scoreboard queue when a block is presented and compared as words transfer.
module tb_aes_word_serializer;

  localparam int unsigned WORD_W = 32;

  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic [4*WORD_W-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WORD_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                busy;
  logic [7:0]          block_cnt;
`ifdef AES_SER_LAST_EN
  logic                out_last;
  logic [1:0]          word_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // {sel, data} expected per word, in transfer order
  logic [WORD_W+1:0] sb_q[$];

  aes_word_serializer #(.WORD_W(WORD_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef AES_SER_LAST_EN
    .out_last  (out_last),
    .word_cnt  (word_cnt),
`endif
    .block_cnt (block_cnt)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every word transfer is compared against the head of the queue.
  always @(negedge CLK) begin
    if (!RESET && out_valid && out_ready) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got sel=%0d data=%h, want no transfer", out_sel, out_data);
      end else begin
        logic [WORD_W+1:0] exp_w;
        exp_w = sb_q.pop_front();
        if ({out_sel, out_data} !== exp_w)
          $display("FAIL sb_word: got sel=%0d data=%h, want sel=%0d data=%h",
                   out_sel, out_data, exp_w[WORD_W+1:WORD_W], exp_w[WORD_W-1:0]);
        else n_pass++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_block(input logic [4*WORD_W-1:0] blk);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] s;
      s = 2'(i);
      sb_q.push_back({s, blk[(3-i)*WORD_W +: WORD_W]});
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_chk++; if (block_cnt !== 8'd0) $display("FAIL rst_block_cnt: got %0d want 0", block_cnt);
    else n_pass++;
    n_chk++;
    if ({out_sel, out_data} !== {2'd0, 32'h0})
      $display("FAIL rst_hold: got sel=%0d data=%h want sel=0 data=0", out_sel, out_data);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [127:0] blk;
    blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    do_reset();
    in_data = blk; in_valid = 1'b1; out_ready = 1'b1;
    push_block(blk);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i))
        $display("FAIL single_seq%0d: got valid=%b sel=%0d want valid=1 sel=%0d",
                 i, out_valid, out_sel, i);
      else n_pass++;
      tick();
    end
    n_chk++; if (out_valid !== 1'b0) $display("FAIL single_idle: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (block_cnt !== 8'd1) $display("FAIL single_cnt: got %0d want 1", block_cnt);
    else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [127:0] blk;
    logic [6:0]   pat;
    int           k;
    blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    pat = 7'b1101001; // applied LSB first: 1,0,0,1,0,1,1
    k = 0;
    do_reset();
    in_data = blk; in_valid = 1'b1;
    push_block(blk);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      in_data = {4{$urandom()}}; // not accepted; must not disturb the held block
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== 2'(k) || out_data !== blk[(3-k)*WORD_W +: WORD_W])
        $display("FAIL stall_hold%0d: got valid=%b sel=%0d data=%h want valid=1 sel=%0d data=%h",
                 i, out_valid, out_sel, out_data, k, blk[(3-k)*WORD_W +: WORD_W]);
      else n_pass++;
      tick();
      if (pat[i]) k++;
    end
    out_ready = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL stall_idle: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (block_cnt !== 8'd1) $display("FAIL stall_cnt: got %0d want 1", block_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] b1;
    logic [127:0] b2;
    b1 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    b2 = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
    do_reset();
    out_ready = 1'b1;
    in_data = b1; in_valid = 1'b1;
    push_block(b1);
    tick();
    in_data = b2;
    push_block(b2);
    for (int j = 0; j < 8; j++) begin
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== (j % 4 == 3))
        $display("FAIL b2b_cyc%0d: got valid=%b in_ready=%b want valid=1 in_ready=%b",
                 j, out_valid, in_ready, (j % 4 == 3));
      else n_pass++;
      tick();
      if (j == 3) in_valid = 1'b0;
    end
    n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_idle: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (block_cnt !== 8'd2) $display("FAIL b2b_cnt: got %0d want 2", block_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] b1;
    logic [127:0] b2;
    b1 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    b2 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    do_reset();
    out_ready = 1'b1;
    in_data = b1; in_valid = 1'b1;
    push_block(b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    sb_q.delete(); // remaining words of b1 are discarded
    tick();
    RESET = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid);
    else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_chk++; if (block_cnt !== 8'd0) $display("FAIL rmid_cnt: got %0d want 0", block_cnt);
    else n_pass++;
    in_data = b2; in_valid = 1'b1;
    push_block(b2);
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_sel !== 2'd0 || out_data !== b2[127:96])
      $display("FAIL rmid_restart: got sel=%0d data=%h want sel=0 data=%h",
               out_sel, out_data, b2[127:96]);
    else n_pass++;
    repeat (4) tick();
    n_chk++; if (block_cnt !== 8'd1) $display("FAIL rmid_cnt2: got %0d want 1", block_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [127:0] blk;
    int           wait_cyc;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int b = 0; b < 256; b++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_data = blk;
      push_block(blk);
      wait_cyc = 0;
      while (!in_ready && wait_cyc < 10) begin
        tick();
        wait_cyc++;
      end
      if (!in_ready) begin
        n_chk++;
        $display("FAIL wrap_accept%0d: got in_ready=0 want 1 within 10 cycles", b);
      end
      tick();
    end
    in_valid = 1'b0;
    n_chk++; if (block_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", block_cnt);
    else n_pass++;
    repeat (4) tick();
    n_chk++; if (block_cnt !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", block_cnt);
    else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL wrap_idle: got %b want 0", out_valid);
    else n_pass++;
  endtask

`ifdef AES_SER_LAST_EN
  task automatic test_last();
    logic [127:0] blk;
    blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    do_reset();
    out_ready = 1'b1;
    in_data = blk; in_valid = 1'b1;
    push_block(blk);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (out_last !== (i == 3) || word_cnt !== 2'(i))
        $display("FAIL last_w%0d: got last=%b word_cnt=%0d want last=%b word_cnt=%0d",
                 i, out_last, word_cnt, (i == 3), i);
      else n_pass++;
      tick();
    end
    n_chk++; if (out_last !== 1'b0) $display("FAIL last_idle: got %b want 0", out_last);
    else n_pass++;
  endtask
`endif

  task automatic test_drain();
    n_chk++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_drain();
    test_stall();
    test_drain();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    test_drain();
    test_wrap();
    test_drain();
`ifdef AES_SER_LAST_EN
    test_last();
    test_drain();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_word_serializer.md
Name: aes_word_serializer

Overview:
- Unpacks one 128-bit AES state into four 32-bit words and emits them in sequence over a valid/ready handshake.
- It is the read-side counterpart of the word-assembly register used in the InvMixColumns path.
- It feeds the per-word column datapath from a full state.
- Each emitted word carries its 2-bit word index, encoded so it can drive the assembly register's select directly.

Parameters:
- WORD_W, 32, width of one word; block width is 4*WORD_W.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- in_data  in  4*WORD_W  block to serialize
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepted when in_valid & in_ready
- out_data  out  WORD_W  current word
- out_sel  out  2  index of current word (same encoding as assembly select)
- out_valid  out  1  out_data/out_sel valid
- out_ready  in  1  word consumed when out_valid & out_ready
- busy  out  1  high while a block is held
- block_cnt  out  8  count of fully emitted blocks, wraps 255->0

Behaviour:
- Reset: RESET sampled on a CLK edge is the only reset.
  - state=IDLE, idx=0, hold register=0, block_cnt=0.
  - out_valid=0, busy=0, in_ready=1 (IDLE).
  - Reset mid-block discards the held block; no partial block is counted.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture in_data into the hold register, idx<=0, go to SEND.
- SEND:
  - out_valid=1, busy=1, out_sel=word code for idx.
  - out_data is the matching slice of the hold register; both are driven combinationally from registers.
- Word order and encoding:
  - idx0: out_sel=2'd0, bits[4W-1:3W].
  - idx1: out_sel=2'd1, bits[3W-1:2W].
  - idx2: out_sel=2'd2, bits[2W-1:W].
  - idx3: out_sel=2'd3, bits[W-1:0].
  - Most-significant word goes first.
- Word transfer (out_valid & out_ready):
  - idx<3: idx<=idx+1.
  - idx==3: block_cnt<=block_cnt+1.
    - If in_valid, capture the new block, idx<=0, stay in SEND (back-to-back).
    - Otherwise go to IDLE.
- in_ready in SEND = (idx==3) & out_ready. This is the only combinational in-to-out path (out_ready -> in_ready). No other in_valid/in_ready path exists.
- Stall: out_ready=0 holds out_data, out_sel, idx and the hold register unchanged indefinitely. out_valid must not drop.
- Input changes on in_data while in SEND (not accepted) have no effect.
- Latency: first word valid 1 cycle after acceptance.
- Throughput with out_ready=1:
  - Back-to-back blocks: 4 cycles per block, no bubbles.
  - Isolated block: 5 cycles (IDLE accept + 4 words).
- block_cnt wraps modulo 256, no saturation.

Optional Feature:
- Macro: AES_SER_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit) = out_valid & (idx==3).
  - Adds output port word_cnt (2 bits) = idx.
  - Downstream may use these to close a block.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset, then in_data=128'h00112233_44556677_8899AABB_CCDDEEFF with in_valid for 1 cycle, out_ready=1 -> outputs are:
  - 00112233/sel0, 44556677/sel1, 8899AABB/sel2, CCDDEEFF/sel3 on 4 consecutive cycles;
  - then out_valid=0, block_cnt=1, in_ready=1.
- Same block with out_ready toggling 1,0,0,1,0,1,1 -> each word held stable while stalled; exactly 4 transfers in order; block_cnt=1.
- Two blocks presented continuously (in_valid=1), out_ready=1 -> 8 words on 8 consecutive cycles; in_ready pulses high on the idx3 cycle; block_cnt=2.
- RESET asserted after 2 words transferred -> next cycle out_valid=0, in_ready=1, block_cnt unchanged from prior value (0); a fresh block restarts at sel0.
- 256 blocks streamed -> block_cnt wraps to 0.
- AES_SER_LAST_EN defined, single block -> out_last=1 only with CCDDEEFF/sel3; word_cnt steps 0,1,2,3.
